// File: rtl/mealy_recognizer_arbiter_if.sv
// Requester/recognizer signal bundle for the shared Mealy recognizer arbiter.
// The master side is the requester/recognizer environment; the slave side is the arbiter.
interface mealy_recognizer_arbiter_if #(
   parameter int unsigned CNT_W = 4
);
   logic             req0;
   logic             req1;
   logic [1:0]       X0;
   logic [1:0]       X1;
   logic             v0;
   logic             v1;
   logic             last0;
   logic             last1;
   logic             gnt0;
   logic             gnt1;
   logic             rec_clr_;
   logic [1:0]       rec_X;
   logic             rec_z;
   logic             done;
   logic             done_id;
   logic [CNT_W-1:0] hits;
   logic             abort;

   modport master (
      output req0, req1, X0, X1, v0, v1, last0, last1, rec_z,
      input  gnt0, gnt1, rec_clr_, rec_X, done, done_id, hits, abort
   );

   modport slave (
      input  req0, req1, X0, X1, v0, v1, last0, last1, rec_z,
      output gnt0, gnt1, rec_clr_, rec_X, done, done_id, hits, abort
   );
endinterface

// File: rtl/mealy_recognizer_arbiter.sv
// Round-robin frame arbiter sharing one delayed-output 11->01->10 recognizer between two
// symbol streams; counts the recognizer's delayed hits and reports one count per frame.
module mealy_recognizer_arbiter #(
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic                           Ck,
   input  logic                           reset_,
   mealy_recognizer_arbiter_if.slave      bus
);

   localparam int unsigned IDLE_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_REPORT
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_served_q, last_served_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              rec_clr_n_q, rec_clr_n_d;
   logic [1:0]        rec_x_q, rec_x_d;
   logic              done_q, done_d;
   logic              done_id_q, done_id_d;
   logic [CNT_W-1:0]  hits_q, hits_d;
   logic              abort_q, abort_d;
   logic              abort_flag_q, abort_flag_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [1:0]        tag_q, tag_d;
   logic              drain_q, drain_d;

   logic              sel_req_c;
   logic              sel_v_c;
   logic              sel_last_c;
   logic [1:0]        sel_x_c;
   logic              sel_gnt_c;
   logic              accept_c;
   logic [IDLE_W-1:0] idle_inc_c;

   // State and output registers
   always_ff @(posedge Ck or negedge reset_) begin
      if (!reset_) begin
         state_q       <= S_IDLE;
         owner_q       <= 1'b0;
         last_served_q <= 1'b1;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         rec_clr_n_q   <= 1'b0;
         rec_x_q       <= 2'b00;
         done_q        <= 1'b0;
         done_id_q     <= 1'b0;
         hits_q        <= '0;
         abort_q       <= 1'b0;
         abort_flag_q  <= 1'b0;
         cnt_q         <= '0;
         idle_q        <= '0;
         tag_q         <= '0;
         drain_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_served_q <= last_served_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         rec_clr_n_q   <= rec_clr_n_d;
         rec_x_q       <= rec_x_d;
         done_q        <= done_d;
         done_id_q     <= done_id_d;
         hits_q        <= hits_d;
         abort_q       <= abort_d;
         abort_flag_q  <= abort_flag_d;
         cnt_q         <= cnt_d;
         idle_q        <= idle_d;
         tag_q         <= tag_d;
         drain_q       <= drain_d;
      end
   end

   // Owner-side view of the request/symbol ports
   always_comb begin
      sel_req_c  = owner_q ? bus.req1  : bus.req0;
      sel_v_c    = owner_q ? bus.v1    : bus.v0;
      sel_last_c = owner_q ? bus.last1 : bus.last0;
      sel_x_c    = owner_q ? bus.X1    : bus.X0;
      sel_gnt_c  = owner_q ? gnt1_q    : gnt0_q;
      accept_c   = (state_q == S_STREAM) && sel_gnt_c && sel_v_c;
      idle_inc_c = idle_q + IDLE_W'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_served_d = last_served_q;
      gnt0_d        = gnt0_q;
      gnt1_d        = gnt1_q;
      rec_clr_n_d   = 1'b1;
      rec_x_d       = 2'b00;
      done_d        = 1'b0;
      done_id_d     = done_id_q;
      hits_d        = hits_q;
      abort_d       = 1'b0;
      abort_flag_d  = abort_flag_q;
      cnt_d         = cnt_q;
      idle_d        = idle_q;
      tag_d         = {tag_q[0], 1'b0};
      drain_d       = drain_q;

      // tag_q[1] marks the cycle where rec_z belongs to an accepted symbol
      if (tag_q[1] && bus.rec_z && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               owner_d     = (bus.req0 && bus.req1) ? ~last_served_q : bus.req1;
               state_d     = S_CLEAR;
               rec_clr_n_d = 1'b0;
            end
         end

         S_CLEAR: begin
            cnt_d   = '0;
            idle_d  = '0;
            tag_d   = '0;
            gnt0_d  = ~owner_q;
            gnt1_d  = owner_q;
            state_d = S_STREAM;
         end

         S_STREAM: begin
            tag_d[0] = accept_c;
            if (accept_c) begin
               rec_x_d = sel_x_c;
               idle_d  = '0;
            end else begin
               idle_d  = idle_inc_c;
            end
            if (accept_c && sel_last_c) begin
               abort_flag_d = 1'b0;
               state_d      = S_DRAIN;
            end else if (!sel_req_c || (!accept_c && (idle_inc_c == IDLE_W'(TIMEOUT)))) begin
               abort_flag_d = 1'b1;
               state_d      = S_DRAIN;
            end
            if (state_d == S_DRAIN) begin
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               drain_d = 1'b0;
            end
         end

         // Two cycles so the final symbol's delayed rec_z is counted before reporting
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               state_d   = S_REPORT;
               done_d    = 1'b1;
               done_id_d = owner_q;
               hits_d    = cnt_d;
               abort_d   = abort_flag_q;
            end
         end

         S_REPORT: begin
            last_served_d = owner_q;
            state_d       = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.rec_clr_ = rec_clr_n_q;
   assign bus.rec_X    = rec_x_q;
   assign bus.done     = done_q;
   assign bus.done_id  = done_id_q;
   assign bus.hits     = hits_q;
   assign bus.abort    = abort_q;

endmodule
